// File: rtl/ascon_result_serializer_if.sv
// ============================================================================
// Module   : ascon_result_serializer_if
// Purpose  : Bundles the ASCON result capture inputs and the byte-stream
//            handshake toward the UART transmitter.
// Signals  : cipher_i     [1471:0] ciphertext, bits [1471:1464] = first byte
//            tag_i        [127:0]  authentication tag, bits [127:120] first
//            end_ascon_i           one-cycle pulse, cipher_i/tag_i valid
//            data_o       [7:0]    byte toward UART TX
//            data_valid_o          data_o holds a byte to transfer
//            data_ready_i          sink accepts byte when high with valid
//            busy_o                frame held / transmission in progress
//            done_o                one-cycle pulse after last byte accepted
//            overrun_o             sticky: end_ascon_i arrived while busy
// Modports : slave  - the serializer itself
//            master - the environment (ASCON controller plus UART sink)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ascon_result_serializer_if;
  logic [1471:0] cipher_i;
  logic [127:0]  tag_i;
  logic          end_ascon_i;
  logic [7:0]    data_o;
  logic          data_valid_o;
  logic          data_ready_i;
  logic          busy_o;
  logic          done_o;
  logic          overrun_o;

  modport slave (
    input  cipher_i, tag_i, end_ascon_i, data_ready_i,
    output data_o, data_valid_o, busy_o, done_o, overrun_o
  );

  modport master (
    output cipher_i, tag_i, end_ascon_i, data_ready_i,
    input  data_o, data_valid_o, busy_o, done_o, overrun_o
  );
endinterface

`default_nettype wire

// File: rtl/ascon_result_serializer.sv
// ============================================================================
// Module   : ascon_result_serializer
// Purpose  : Captures an ASCON ciphertext (and optionally its tag) on a
//            one-cycle end_ascon_i pulse and streams it out as a byte frame
//            over a valid/ready handshake: START_BYTE, 184 cipher bytes
//            MSB-first, then 16 tag bytes MSB-first when the tag is enabled.
// Ports    : clock_i  - rising-edge clock
//            reset_i  - asynchronous, active-high reset
//            bus      - ascon_result_serializer_if.slave (capture inputs,
//                       byte handshake, busy/done/overrun status)
// Params   : START_BYTE - frame-start marker byte (default 8'h02)
// Config   : define ASCON_SER_TAG_EN to append the 16-byte tag (201-byte
//            frame); otherwise the frame is 185 bytes and tag_i is unused.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_result_serializer #(
  parameter logic [7:0] START_BYTE = 8'h02
) (
  input  wire logic                clock_i,
  input  wire logic                reset_i,
  ascon_result_serializer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SEND_START  = 3'd1,
    SEND_CIPHER = 3'd2,
    SEND_TAG    = 3'd3,
    DONE        = 3'd4
  } state_t;

  localparam logic [7:0] LAST_CIPHER = 8'd183;
  localparam logic [7:0] LAST_TAG    = 8'd15;

  state_t        state;
  state_t        state_next;
  logic [7:0]    count;
  logic [7:0]    count_next;
  logic [1471:0] cipher_buf;
  logic          overrun;

  logic          capture;
  logic          sending;
  logic          busy;
  logic          done;
  logic [7:0]    data;
  logic [7:0]    cipher_byte;

  // A new result is only taken when no frame is in flight; DONE counts as
  // free so back-to-back frames lose no cycle.
  assign capture = bus.end_ascon_i && ((state == IDLE) || (state == DONE));

  // Byte k sits at [1471-8k -: 8]; written as (183-k)*8 from the LSB side.
  assign cipher_byte = cipher_buf[{LAST_CIPHER - count, 3'b000} +: 8];

`ifdef ASCON_SER_TAG_EN
  logic [127:0] tag_buf;
  logic [7:0]   tag_byte;
  assign tag_byte = tag_buf[{LAST_TAG[3:0] - count[3:0], 3'b000} +: 8];
`else
  logic unused_tag;
  assign unused_tag = ^bus.tag_i;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      count <= 8'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    count_next = count;
    sending    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    data       = 8'h00;

    case (state)
      IDLE: begin
        if (capture) begin
          state_next = SEND_START;
          count_next = 8'd0;
        end
      end

      SEND_START: begin
        sending = 1'b1;
        busy    = 1'b1;
        data    = START_BYTE;
        if (bus.data_ready_i) begin
          state_next = SEND_CIPHER;
        end
      end

      SEND_CIPHER: begin
        sending = 1'b1;
        busy    = 1'b1;
        data    = cipher_byte;
        if (bus.data_ready_i) begin
          if (count == LAST_CIPHER) begin
            count_next = 8'd0;
`ifdef ASCON_SER_TAG_EN
            state_next = SEND_TAG;
`else
            state_next = DONE;
`endif
          end else begin
            count_next = count + 8'd1;
          end
        end
      end

`ifdef ASCON_SER_TAG_EN
      SEND_TAG: begin
        sending = 1'b1;
        busy    = 1'b1;
        data    = tag_byte;
        if (bus.data_ready_i) begin
          if (count == LAST_TAG) begin
            count_next = 8'd0;
            state_next = DONE;
          end else begin
            count_next = count + 8'd1;
          end
        end
      end
`endif

      DONE: begin
        done = 1'b1;
        if (capture) begin
          state_next = SEND_START;
          count_next = 8'd0;
        end else begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        count_next = 8'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Capture buffer and sticky overrun flag. The buffer is written only on a
  // capture, so it holds still for the whole frame whatever the inputs do.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cipher_buf <= '0;
`ifdef ASCON_SER_TAG_EN
      tag_buf    <= '0;
`endif
      overrun    <= 1'b0;
    end else begin
      if (capture) begin
        cipher_buf <= bus.cipher_i;
`ifdef ASCON_SER_TAG_EN
        tag_buf    <= bus.tag_i;
`endif
        overrun    <= 1'b0;
      end else if (bus.end_ascon_i && busy) begin
        overrun    <= 1'b1;
      end
    end
  end

  assign bus.data_o       = data;
  assign bus.data_valid_o = sending;
  assign bus.busy_o       = busy;
  assign bus.done_o       = done;
  assign bus.overrun_o    = overrun;

endmodule

`default_nettype wire

// File: tb/tb_ascon_result_serializer.sv
// ============================================================================
// Module   : tb_ascon_result_serializer
// Purpose  : Self-checking bench for ascon_result_serializer. Frames are
//            described by a record table (data pattern, sink-ready pattern,
//            expected done cycle, optional mid-frame event); expected bytes
//            go into a scoreboard queue at capture and are popped on every
//            accepted transfer. Hand-written sequences cover back-to-back
//            capture in DONE and reset mid-frame.
// Config   : honours ASCON_SER_TAG_EN (201- vs 185-byte frames).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ascon_result_serializer;

  localparam logic [7:0] START = 8'h02;
`ifdef ASCON_SER_TAG_EN
  localparam int NB = 201;
`else
  localparam int NB = 185;
`endif

  typedef struct {
    int pat;       // 0: byte k = k, 1: byte k = FF-k, 2: random
    int mode;      // 0: ready always, 1: ready on odd cycles, 2: every 3rd
    int exp_done;  // cycle (counted from capture) where done_o is seen
    int inj_at;    // accepted-byte count at which to inject an event
    int inj_kind;  // 0: none, 1: extra end_ascon pulse, 2: reset pulse
  } vec_t;

  logic clock_i = 1'b0;
  logic reset_i;
  always #5 clock_i = ~clock_i;

  ascon_result_serializer_if bus ();

  ascon_result_serializer #(.START_BYTE(START)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build(input int pat, output logic [1471:0] c, output logic [127:0] t);
    logic [7:0] b;
    for (int k = 0; k < 184; k++) begin
      case (pat)
        0:       b = 8'(k);
        1:       b = 8'hFF - 8'(k);
        default: b = 8'($urandom);
      endcase
      c[1471-8*k -: 8] = b;
    end
    for (int k = 0; k < 16; k++) begin
      case (pat)
        0:       b = 8'hF0 + 8'(k);
        1:       b = 8'h0F - 8'(k);
        default: b = 8'($urandom);
      endcase
      t[127-8*k -: 8] = b;
    end
  endtask

  task automatic push_frame(input logic [1471:0] c, input logic [127:0] t);
    exp_q.push_back(START);
    for (int k = 0; k < 184; k++) exp_q.push_back(c[1471-8*k -: 8]);
`ifdef ASCON_SER_TAG_EN
    for (int k = 0; k < 16; k++) exp_q.push_back(t[127-8*k -: 8]);
`endif
  endtask

  function automatic bit ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 1;
      default: return (cyc % 3) == 0;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done_o is seen (or
  // after a reset injection / timeout).
  task automatic run_frame(input logic [1471:0] c, input logic [127:0] t, input vec_t v);
    int         cyc = 1;
    int         accepted = 0;
    bit         got_done = 0;
    bit         held_v = 0;
    bit         injected = 0;
    bit         rdy;
    logic [7:0] held = 8'h00;

    bus.cipher_i     = c;
    bus.tag_i        = t;
    bus.end_ascon_i  = 1'b1;
    bus.data_ready_i = 1'b0;
    push_frame(c, t);
    @(negedge clock_i);
    bus.end_ascon_i = 1'b0;
    bus.cipher_i    = ~c;       // the captured copy must not follow
    bus.tag_i       = ~t;
    chk("overrun_clear_on_capture", 32'(bus.overrun_o), 32'd0);
    chk("first_byte_latency", 32'(bus.data_valid_o), 32'd1);

    while (!got_done && cyc < 4*NB + 20) begin
      if (v.inj_kind == 2 && accepted == v.inj_at) begin
        reset_i = 1'b1;
        #1;
        chk("rst_data",    32'(bus.data_o),       32'd0);
        chk("rst_valid",   32'(bus.data_valid_o), 32'd0);
        chk("rst_busy",    32'(bus.busy_o),       32'd0);
        chk("rst_done",    32'(bus.done_o),       32'd0);
        chk("rst_overrun", 32'(bus.overrun_o),    32'd0);
        exp_q.delete();
        @(negedge clock_i);
        reset_i          = 1'b0;
        bus.data_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clock_i);
          chk("no_done_after_abort", {bus.done_o, bus.data_valid_o}, 32'd0);
        end
        return;
      end
      if (injected && bus.end_ascon_i) begin
        bus.end_ascon_i = 1'b0;
        chk("overrun_set", 32'(bus.overrun_o), 32'd1);
      end

      if (bus.done_o) begin
        got_done = 1;
        chk("done_cycle", 32'(cyc), 32'(v.exp_done));
        chk("done_idle_outputs", {bus.busy_o, bus.data_valid_o}, 32'd0);
        chk("overrun_at_done", 32'(bus.overrun_o), 32'(v.inj_kind == 1));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      end else begin
        chk("busy_valid", {bus.busy_o, bus.data_valid_o}, 32'd3);
        if (held_v) chk("stall_hold", 32'(bus.data_o), 32'(held));
        rdy = ready_for(v.mode, cyc);
        if (rdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", 32'(bus.data_o), 32'hFFFF_FFFF);
          end else begin
            chk("frame_byte", 32'(bus.data_o), 32'(exp_q.pop_front()));
          end
          accepted++;
          held_v = 0;
        end else begin
          held   = bus.data_o;
          held_v = 1;
        end
        bus.data_ready_i = rdy;
        if (v.inj_kind == 1 && !injected && accepted == v.inj_at) begin
          injected        = 1;
          bus.end_ascon_i = 1'b1;
          bus.cipher_i    = {46{32'hDEAD_BEEF}};
          bus.tag_i       = {4{32'h1234_5678}};
        end
        @(negedge clock_i);
        cyc++;
      end
    end
    if (!got_done) chk("done_timeout", 32'd0, 32'd1);
    bus.data_ready_i = 1'b0;
    bus.end_ascon_i  = 1'b0;
  endtask

  vec_t          vecs[4];
  vec_t          v;
  logic [1471:0] c;
  logic [127:0]  t;

  initial begin
    vecs[0] = '{pat: 0, mode: 0, exp_done: NB + 1,   inj_at: -1, inj_kind: 0};
    vecs[1] = '{pat: 0, mode: 1, exp_done: 2 * NB,   inj_at: -1, inj_kind: 0};
    vecs[2] = '{pat: 1, mode: 2, exp_done: 3*NB + 1, inj_at: -1, inj_kind: 0};
    vecs[3] = '{pat: 2, mode: 0, exp_done: NB + 1,   inj_at: 50, inj_kind: 1};

    reset_i          = 1'b1;
    bus.cipher_i     = '0;
    bus.tag_i        = '0;
    bus.end_ascon_i  = 1'b0;
    bus.data_ready_i = 1'b0;
    repeat (2) @(negedge clock_i);
    chk("reset_outputs", {bus.data_o, bus.data_valid_o, bus.busy_o, bus.done_o, bus.overrun_o}, 32'd0);
    reset_i = 1'b0;
    @(negedge clock_i);

    // Ready high while idle must not produce anything.
    bus.data_ready_i = 1'b1;
    repeat (3) @(negedge clock_i);
    chk("idle_ready_ignored", {bus.data_valid_o, bus.busy_o, bus.done_o}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      build(v.pat, c, t);
      run_frame(c, t, v);
      @(negedge clock_i);
      chk("idle_after_done", {bus.done_o, bus.data_valid_o, bus.busy_o}, 32'd0);
    end

    // Overrun frame, then a new capture in the DONE cycle itself: the new
    // frame must start at once with overrun cleared.
    build(2, c, t);
    v = '{pat: 2, mode: 0, exp_done: NB + 1, inj_at: 50, inj_kind: 1};
    run_frame(c, t, v);
    chk("done_before_b2b", 32'(bus.done_o), 32'd1);
    build(0, c, t);
    v = '{pat: 0, mode: 0, exp_done: NB + 1, inj_at: -1, inj_kind: 0};
    run_frame(c, t, v);
    @(negedge clock_i);

    // Reset at byte 100 aborts the frame; the next capture is a fresh frame.
    build(1, c, t);
    v = '{pat: 1, mode: 0, exp_done: NB + 1, inj_at: 100, inj_kind: 2};
    run_frame(c, t, v);
    build(0, c, t);
    v = '{pat: 0, mode: 0, exp_done: NB + 1, inj_at: -1, inj_kind: 0};
    run_frame(c, t, v);
    @(negedge clock_i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ascon_result_serializer.md
ASCON_RESULT_SERIALIZER -- requirements
Module: ascon_result_serializer

Interface
REQ-001 SHALL have parameter START_BYTE, default 8'h02, frame-start marker byte sent before payload.
REQ-002 SHALL have ports clock_i in 1, single rising-edge clock.
REQ-003 SHALL have port reset_i in 1; reset is asynchronous and active-high.
REQ-004 SHALL have port cipher_i in 1472, ciphertext from ASCON controller, bits [1471:1464] = first byte.
REQ-005 SHALL have port tag_i in 128, authentication tag, bits [127:120] = first tag byte.
REQ-006 SHALL have port end_ascon_i in 1, one-cycle pulse: cipher_i/tag_i valid this cycle.
REQ-007 SHALL have port data_o out 8, byte toward UART TX.
REQ-008 SHALL have port data_valid_o out 1, data_o holds a byte to transfer.
REQ-009 SHALL have port data_ready_i in 1, sink accepts byte when high with data_valid_o.
REQ-010 SHALL have port busy_o out 1, frame capture held / transmission in progress.
REQ-011 SHALL have port done_o out 1, one-cycle pulse after last byte accepted.
REQ-012 SHALL have port overrun_o out 1, sticky: end_ascon_i arrived while busy.

Function
REQ-013 SHALL implement states IDLE, SEND_START, SEND_CIPHER, SEND_TAG, DONE.
REQ-014 In IDLE or DONE, end_ascon_i=1 SHALL capture cipher_i and tag_i into internal 1600-bit buffer, clear byte counter, clear overrun_o, go to SEND_START.
REQ-015 data_valid_o SHALL rise the cycle after capture edge (latency 1) with data_o=START_BYTE.
REQ-016 Transfer SHALL occur on an edge where data_valid_o=1 and data_ready_i=1; data_o and data_valid_o SHALL stay constant while data_valid_o=1 and data_ready_i=0.
REQ-017 data_valid_o SHALL be asserted continuously in SEND_* states (no bubbles between bytes when data_ready_i stays high: one byte per cycle).
REQ-018 SEND_CIPHER SHALL emit 184 bytes MSB-first, byte k = cipher buffer [1471-8k : 1464-8k], 8-bit counter 0..183.
REQ-019 SEND_TAG SHALL emit 16 bytes MSB-first, byte k = tag buffer [127-8k : 120-8k], counter reused 0..15.
REQ-020 Transition on accepted last byte (counter 183 in SEND_CIPHER, or 15 in SEND_TAG) SHALL go to next state and reset counter to 0.
REQ-021 DONE SHALL last exactly one cycle with done_o=1, busy_o=0, data_valid_o=0, then IDLE unless a capture occurs (REQ-014).
REQ-022 busy_o SHALL be 1 in SEND_START, SEND_CIPHER, SEND_TAG only.
REQ-023 end_ascon_i=1 in any SEND_* state SHALL be ignored for data, set overrun_o=1, not disturb the frame in flight.
REQ-024 Captured buffer SHALL not change during transmission regardless of cipher_i/tag_i activity.
REQ-025 data_ready_i=1 while data_valid_o=0 SHALL have no effect.

Reset
REQ-026 reset_i=1 SHALL asynchronously force IDLE, counter 0, buffer 0, data_o=0, data_valid_o=0, busy_o=0, done_o=0, overrun_o=0.
REQ-027 Reset mid-frame SHALL abort it; no done_o pulse; first post-reset capture starts a fresh frame from START_BYTE.

Configuration
REQ-028 Macro ASCON_SER_TAG_EN defined: SEND_CIPHER proceeds to SEND_TAG, frame = 1+184+16 = 201 bytes.
REQ-029 Macro ASCON_SER_TAG_EN undefined: SEND_TAG and tag buffer absent, SEND_CIPHER goes directly to DONE, frame = 185 bytes, tag_i unused.

Verification
REQ-030 Reset, then end_ascon_i pulse with cipher_i = byte k value k (k=0..183), tag_i bytes 8'hF0..8'hFF, data_ready_i=1 -> 02,00..B7,F0..FF on consecutive cycles, done_o one cycle after byte 201 (185 bytes, no tag, without macro).
REQ-031 Same frame with data_ready_i toggled 1-0 every cycle -> identical byte sequence, data_o stable during each stall, 2x duration.
REQ-032 Second end_ascon_i pulse at byte 50 with different data -> overrun_o=1, emitted frame unchanged; next capture after done_o clears overrun_o.
REQ-033 reset_i=1 asserted at byte 100 for 1 cycle -> all outputs 0 immediately, no done_o; next capture emits full frame starting 02.
REQ-034 end_ascon_i asserted in DONE cycle -> done_o=1 that cycle, new frame START_BYTE valid next cycle, overrun_o=0.
